muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand width.
REQ-002 SHALL have parameter M, default 4, meaning alu_decode width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have port start, input, 1, request strobe, sampled only in IDLE.
REQ-006 SHALL have port alu_decode, input, M, op code: 4'b0101 MUL, 4'b0110 DIV.
REQ-007 SHALL have port rda, input, N, multiplicand or dividend.
REQ-008 SHALL have port rdx, input, N, multiplier or divisor.
REQ-009 SHALL have port busy, output, 1, high while iterating.
REQ-010 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-011 SHALL have port hi, output, N, Hi register: product[2N-1:N] or remainder.
REQ-012 SHALL have port lo, output, N, Lo register: product[N-1:0] or quotient.
REQ-013 SHALL have port div_by_zero, output, 1, sticky flag for the last completed op.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-015 SHALL, in IDLE, move to MUL when start=1 and alu_decode=0101, or to DIV when start=1 and alu_decode=0110, with rda/rdx latched internally at that edge.
REQ-016 SHALL ignore start with any other alu_decode value, staying in IDLE with no output change.
REQ-017 SHALL ignore start in MUL, DIV and DONE; latched operands are not disturbed by input changes.
REQ-018 SHALL compute MUL as unsigned shift-add, one bit per cycle, N iterations, giving a full 2N-bit product.
REQ-019 SHALL compute DIV as unsigned restoring division, one bit per cycle, N iterations.
REQ-020 SHALL use a log2(N)+1-bit iteration counter cleared on entry to MUL/DIV; after the Nth iteration the FSM moves to DONE.
REQ-021 SHALL give latency as follows: start accepted at edge k; MUL/DIV during cycles k+1..k+N; DONE (done=1) at cycle k+N+1; IDLE at k+N+2.
REQ-022 SHALL update hi and lo only on entry to DONE; otherwise they hold their last completed values.
REQ-023 SHALL, on DIV with rdx=0, skip iteration: DONE at cycle k+1 with lo=all ones, hi=rda, div_by_zero=1.
REQ-024 SHALL set div_by_zero=0 on every other completion.
REQ-025 SHALL drive busy=1 exactly in MUL and DIV, and done=1 exactly in DONE; busy and done are never high together.
REQ-026 SHALL accept a new start in the cycle after DONE, i.e. back-to-back throughput of one op per N+2 cycles.

Reset
REQ-027 SHALL, on rst_n=0 at any time including mid-operation, immediately force IDLE and set busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0, and clear internal operand registers.
REQ-028 SHALL ignore start while rst_n=0; the first start can be accepted at the first rising edge after deassertion.

Structure
REQ-029 SHALL take the op-code constants (ALU_MUL=4'b0101, ALU_DIV=4'b0110 and the remaining ALU codes) and the FSM state enum from a shared package alu_pkg, which the ALU also uses.
REQ-030 SHALL be a single module with no sub-modules; the datapath (2N-bit accumulator/remainder shift register) lives inline.

Verification
REQ-031 SHALL check: MUL 7 x 6 -> done exactly 33 cycles after the start edge, hi=0x00000000, lo=0x0000002A, div_by_zero=0.
REQ-032 SHALL check: MUL 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 SHALL check: DIV 100 / 7 -> lo=14, hi=2 after 33 cycles; then DIV 5 / 0 -> done 1 cycle after start, lo=0xFFFFFFFF, hi=5, div_by_zero=1.
REQ-034 SHALL check: start with alu_decode=0001, and start pulsed while busy with different operands -> no state change and no corruption of the in-flight result.
REQ-035 SHALL check: rst_n low at iteration 10 of a MUL -> outputs zero immediately, IDLE; a new MUL 3 x 3 afterwards -> lo=9.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU op-code constants and the multiply/divide sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_DIV = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
module muldiv_unit
  import alu_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] alu_decode,
  input  logic [N-1:0] rda,
  input  logic [N-1:0] rdx,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N) + 1;

  muldiv_state_e  state;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_next;
  logic [N-1:0]   opa;
  logic [N:0]     mul_sum;
  logic [N:0]     div_trial;
  logic           last;

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    mul_sum   = {1'b0, acc[2*N-1:N]};
    if (acc[0]) mul_sum = {1'b0, acc[2*N-1:N]} + {1'b0, opa};
    div_trial = {acc[2*N-1:N], acc[N-1]} - {1'b0, opa};
    acc_next  = acc;
    case (state)
      ST_MUL: acc_next = {mul_sum, acc[N-1:1]};
      ST_DIV: begin
        if (div_trial[N]) acc_next = {acc[2*N-2:0], 1'b0};
        else              acc_next = {div_trial[N-1:0], acc[N-2:0], 1'b1};
      end
      default: acc_next = acc;
    endcase
    last = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      acc         <= '0;
      opa         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && alu_decode == M'(ALU_MUL)) begin
            state <= ST_MUL;
            busy  <= 1'b1;
            cnt   <= '0;
            acc   <= {{N{1'b0}}, rdx};
            opa   <= rda;
          end else if (start && alu_decode == M'(ALU_DIV)) begin
            if (rdx == '0) begin
              state       <= ST_DONE;
              done        <= 1'b1;
              hi          <= rda;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              state <= ST_DIV;
              busy  <= 1'b1;
              cnt   <= '0;
              acc   <= {{N{1'b0}}, rda};
              opa   <= rdx;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (last) begin
            state       <= ST_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            hi          <= acc_next[2*N-1:N];
            lo          <= acc_next[N-1:0];
            div_by_zero <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
